// File: rtl/cps1_sync_lock_ctrl.sv
// Lock qualifier for the CPS1 capture path: measures line/frame timing from the
// sync frontend and opens the DE gate only after the timing has proven stable.
module cps1_sync_lock_ctrl #(
  parameter int H_NOM         = 1024,
  parameter int H_TOL         = 4,
  parameter int V_NOM         = 262,
  parameter int V_TOL         = 2,
  parameter int LOCK_FRAMES   = 4,
  parameter int UNLOCK_FRAMES = 2,
  parameter int WDOG_BITS     = 20
) (
  input  logic        PCLK2x_i,
  input  logic        reset_n,
  input  logic        HSYNC_i,
  input  logic        DE_i,
  input  logic        frame_change_i,
  output logic        DE_o,
  output logic        locked_o,
  output logic [10:0] h_meas_o,
  output logic [9:0]  v_meas_o,
  output logic        frame_ok_o,
  output logic        wdog_timeout_o
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam logic [11:0] H_MAX      = 12'(H_NOM + H_TOL);
  localparam logic [11:0] H_MIN      = 12'(H_NOM - H_TOL);
  localparam logic [10:0] V_MAX      = 11'(V_NOM + V_TOL);
  localparam logic [10:0] V_MIN      = 11'(V_NOM - V_TOL);
  localparam logic [3:0]  LOCK_N     = 4'(LOCK_FRAMES);
  localparam logic [3:0]  UNLOCK_N   = 4'(UNLOCK_FRAMES);
  localparam logic [10:0] H_CNT_MAX  = 11'h7FF;
  localparam logic [9:0]  LINE_MAX   = 10'h3FF;
  localparam logic [WDOG_BITS-1:0] WD_MAX = '1;

  logic hs_q, hs_d, hs_dly_q, hs_dly_d;
  logic fc_q, fc_d, fc_dly_q, fc_dly_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [10:0] h_meas_q, h_meas_d;
  logic [9:0]  v_meas_q, v_meas_d;
  logic        bad_line_q, bad_line_d;
  logic        seen_fs_q, seen_fs_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [WDOG_BITS-1:0] wd_cnt_q, wd_cnt_d;
  state_t      state_q, state_d;
  logic        locked_q, locked_d;
  logic        de_q, de_d;
  logic        frame_ok_q, frame_ok_d;
  logic        wdog_q, wdog_d;

  logic        ls, fs, ls_any;
  logic [11:0] h_len_raw;
  logic [10:0] h_len_sat;
  logic        line_bad, v_ok, frame_valid;
  logic [3:0]  cnt_inc;

  // Events are derived from the registered copies, so they act one cycle after sampling.
  assign ls     = hs_dly_q & ~hs_q;
  assign fs     = fc_q & ~fc_dly_q;
  assign ls_any = ls | fs;

  assign h_len_raw   = {1'b0, h_cnt_q} + 12'd1;
  assign h_len_sat   = h_len_raw[11] ? H_CNT_MAX : h_len_raw[10:0];
  assign line_bad    = ({1'b0, h_len_sat} > H_MAX) || ({1'b0, h_len_sat} < H_MIN);
  assign v_ok        = ({1'b0, line_cnt_q} >= V_MIN) && ({1'b0, line_cnt_q} <= V_MAX);
  // The line closing at the frame start counts toward the frame it closes.
  assign frame_valid = seen_fs_q & ~(bad_line_q | line_bad) & v_ok;
  assign cnt_inc     = cnt_q + 4'd1;

  always_comb begin
    hs_d       = HSYNC_i;
    hs_dly_d   = hs_q;
    fc_d       = frame_change_i;
    fc_dly_d   = fc_q;
    h_cnt_d    = (h_cnt_q == H_CNT_MAX) ? h_cnt_q : h_cnt_q + 11'd1;
    line_cnt_d = line_cnt_q;
    h_meas_d   = h_meas_q;
    v_meas_d   = v_meas_q;
    bad_line_d = bad_line_q;
    seen_fs_d  = seen_fs_q;
    cnt_d      = cnt_q;
    wd_cnt_d   = wd_cnt_q;
    state_d    = state_q;
    frame_ok_d = 1'b0;
    wdog_d     = 1'b0;
    de_d       = DE_i & locked_q;

    if (ls_any) begin
      h_cnt_d  = 11'd0;
      h_meas_d = h_len_sat;
      if (!fs) begin
        if (line_bad) begin
          bad_line_d = 1'b1;
        end
        if (line_cnt_q != LINE_MAX) begin
          line_cnt_d = line_cnt_q + 10'd1;
        end
      end
    end

    if (fs) begin
      v_meas_d   = line_cnt_q;
      line_cnt_d = 10'd1;
      bad_line_d = 1'b0;
      seen_fs_d  = 1'b1;
      wd_cnt_d   = '0;
      frame_ok_d = frame_valid;
      case (state_q)
        ST_SEARCH: begin
          if (frame_valid) begin
            if (LOCK_FRAMES == 1) begin
              state_d = ST_LOCKED;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_ACQUIRE;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_ACQUIRE: begin
          if (!frame_valid) begin
            state_d = ST_SEARCH;
            cnt_d   = 4'd0;
          end else if (cnt_inc == LOCK_N) begin
            state_d = ST_LOCKED;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_LOCKED: begin
          if (!frame_valid) begin
            if (UNLOCK_FRAMES == 1) begin
              state_d = ST_SEARCH;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (frame_valid) begin
            state_d = ST_LOCKED;
            cnt_d   = 4'd0;
          end else if (cnt_inc == UNLOCK_N) begin
            state_d = ST_SEARCH;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          cnt_d   = 4'd0;
        end
      endcase
    end else if (wd_cnt_q != WD_MAX) begin
      // Expiry fires once on the step into all-ones; the counter then parks until the next FS.
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_MAX - 1'b1) begin
        wdog_d    = 1'b1;
        state_d   = ST_SEARCH;
        cnt_d     = 4'd0;
        seen_fs_d = 1'b0;
      end
    end

    locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
  end

  always_ff @(posedge PCLK2x_i or negedge reset_n) begin
    if (!reset_n) begin
      hs_q       <= 1'b1;
      hs_dly_q   <= 1'b1;
      fc_q       <= 1'b0;
      fc_dly_q   <= 1'b0;
      h_cnt_q    <= 11'd0;
      line_cnt_q <= 10'd0;
      h_meas_q   <= 11'd0;
      v_meas_q   <= 10'd0;
      bad_line_q <= 1'b0;
      seen_fs_q  <= 1'b0;
      cnt_q      <= 4'd0;
      wd_cnt_q   <= '0;
      state_q    <= ST_SEARCH;
      locked_q   <= 1'b0;
      de_q       <= 1'b0;
      frame_ok_q <= 1'b0;
      wdog_q     <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      hs_dly_q   <= hs_dly_d;
      fc_q       <= fc_d;
      fc_dly_q   <= fc_dly_d;
      h_cnt_q    <= h_cnt_d;
      line_cnt_q <= line_cnt_d;
      h_meas_q   <= h_meas_d;
      v_meas_q   <= v_meas_d;
      bad_line_q <= bad_line_d;
      seen_fs_q  <= seen_fs_d;
      cnt_q      <= cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      state_q    <= state_d;
      locked_q   <= locked_d;
      de_q       <= de_d;
      frame_ok_q <= frame_ok_d;
      wdog_q     <= wdog_d;
    end
  end

  assign DE_o           = de_q;
  assign locked_o       = locked_q;
  assign h_meas_o       = h_meas_q;
  assign v_meas_o       = v_meas_q;
  assign frame_ok_o     = frame_ok_q;
  assign wdog_timeout_o = wdog_q;

endmodule

// File: tb/tb_cps1_sync_lock_ctrl.sv
// Bench for cps1_sync_lock_ctrl: scaled-down timing, frame-level reference model
// that tracks good/bad frame runs and predicts lock, measurements and pulses.
module tb_cps1_sync_lock_ctrl;

  localparam int H_NOM         = 32;
  localparam int H_TOL         = 2;
  localparam int V_NOM         = 10;
  localparam int V_TOL         = 1;
  localparam int LOCK_FRAMES   = 4;
  localparam int UNLOCK_FRAMES = 2;
  localparam int WDOG_BITS     = 10;
  localparam int WD_MAX        = (1 << WDOG_BITS) - 1;

  logic        clk;
  logic        rst_n;
  logic        hsync;
  logic        de_in;
  logic        fc;
  logic        DE_o;
  logic        locked_o;
  logic [10:0] h_meas_o;
  logic [9:0]  v_meas_o;
  logic        frame_ok_o;
  logic        wdog_timeout_o;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  int ok_prev = 0;
  int last_fs_cyc = 0;

  bit m_seen = 0;
  bit m_locked = 0;
  int m_good = 0;
  int m_bad = 0;
  int cur_lens[$];
  int plan[$];
  logic [23:0] exp_q[$];

  cps1_sync_lock_ctrl #(
    .H_NOM(H_NOM), .H_TOL(H_TOL), .V_NOM(V_NOM), .V_TOL(V_TOL),
    .LOCK_FRAMES(LOCK_FRAMES), .UNLOCK_FRAMES(UNLOCK_FRAMES), .WDOG_BITS(WDOG_BITS)
  ) dut (
    .PCLK2x_i(clk),
    .reset_n(rst_n),
    .HSYNC_i(hsync),
    .DE_i(de_in),
    .frame_change_i(fc),
    .DE_o(DE_o),
    .locked_o(locked_o),
    .h_meas_o(h_meas_o),
    .v_meas_o(v_meas_o),
    .frame_ok_o(frame_ok_o),
    .wdog_timeout_o(wdog_timeout_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_ok_o) ok_cnt <= ok_cnt + 1;
    if (wdog_timeout_o) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: one call per frame start, judging the frame that just closed
  task automatic model_close();
    int n;
    int last;
    bit valid;
    bit hv;
    n = cur_lens.size();
    last = (n > 0) ? cur_lens[n-1] : 0;
    hv = m_seen;
    valid = 1'b0;
    if (!m_seen) begin
      m_seen = 1'b1;
    end else begin
      valid = (n >= V_NOM - V_TOL) && (n <= V_NOM + V_TOL);
      foreach (cur_lens[i])
        if (cur_lens[i] < H_NOM - H_TOL || cur_lens[i] > H_NOM + H_TOL) valid = 1'b0;
      if (m_locked) begin
        if (valid) m_bad = 0;
        else begin
          m_bad++;
          if (m_bad >= UNLOCK_FRAMES) begin
            m_locked = 1'b0;
            m_good = 0;
          end
        end
      end else begin
        if (valid) begin
          m_good++;
          if (m_good >= LOCK_FRAMES) begin
            m_locked = 1'b1;
            m_bad = 0;
          end
        end else m_good = 0;
      end
    end
    exp_q.push_back({hv, valid, m_locked, 10'(n > 1023 ? 1023 : n), 11'(last > 2047 ? 2047 : last)});
    cur_lens.delete();
  endtask

  task automatic model_reset();
    m_seen = 1'b0;
    m_locked = 1'b0;
    m_good = 0;
    m_bad = 0;
  endtask

  task automatic check_frame();
    logic [23:0] e;
    int d;
    model_close();
    e = exp_q.pop_front();
    d = ok_cnt - ok_prev;
    ok_prev = ok_cnt;
    check_eq("frame_ok", 32'(d), 32'(e[22]));
    check_eq("locked", 32'(locked_o), 32'(e[21]));
    if (e[23]) begin
      check_eq("v_meas", 32'(v_meas_o), 32'(e[20:11]));
      check_eq("h_meas", 32'(h_meas_o), 32'(e[10:0]));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq(tag, 32'({DE_o, locked_o, h_meas_o, v_meas_o, frame_ok_o, wdog_timeout_o}), 32'd0);
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_mid_outs");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outs("rst_mid_hold");
    rst_n = 1'b1;
    model_reset();
  endtask

  // driver: plays plan[] as one frame, FS on line 0
  task automatic drive_frame(input int rst_line);
    for (int ln = 0; ln < plan.size(); ln++) begin
      int len;
      len = plan[ln];
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        #1;
        if (c == 12) check_eq("de_o", 32'(DE_o), 32'(de_in & m_locked));
        if (ln == 0 && c == 6) check_frame();
        if (ln == 0 && c == 0) last_fs_cyc = cyc;
        hsync = (c >= 4);
        fc = (ln == 0 && c < 8);
        de_in = (c >= 8 && c < len - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (ln == rst_line && c == 10) reset_mid();
      end
      cur_lens.push_back(len);
    end
  endtask

  task automatic plan_frame(input int n);
    plan.delete();
    for (int i = 0; i < n; i++) plan.push_back(H_NOM);
  endtask

  task automatic run_nominal(input int frames);
    for (int f = 0; f < frames; f++) begin
      plan_frame(V_NOM);
      drive_frame(-1);
    end
  endtask

  task automatic wdog_test();
    int base;
    int waited;
    plan.delete();
    plan.push_back(20);
    drive_frame(-1);
    hsync = 1'b1;
    fc = 1'b0;
    de_in = 1'b1;
    base = to_cnt;
    waited = 0;
    while (to_cnt == base && waited < WD_MAX + 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("wdog_pulse", 32'(to_cnt - base), 32'd1);
    check_eq("wdog_cyc", 32'(to_cyc), 32'(last_fs_cyc + 2 + WD_MAX));
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("wdog_locked", 32'(locked_o), 32'(m_locked));
    check_eq("wdog_de", 32'(DE_o), 32'(de_in & m_locked));
    repeat (WD_MAX + 200) @(posedge clk);
    #1;
    check_eq("wdog_repeat", 32'(to_cnt - base), 32'd1);
    de_in = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    hsync = 1'b1;
    fc = 1'b0;
    de_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset_outs");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // acquire from reset
    run_nominal(6);
    // single long frame -> hold, then recover
    plan_frame(V_NOM + 3); drive_frame(-1);
    run_nominal(2);
    // two long frames -> unlock
    plan_frame(V_NOM + 3); drive_frame(-1);
    plan_frame(V_NOM + 3); drive_frame(-1);
    run_nominal(2);
    // out-of-tolerance line while acquiring
    plan_frame(V_NOM); plan[4] = H_NOM + H_TOL + 3; drive_frame(-1);
    run_nominal(5);

    // tolerance boundaries
    plan_frame(V_NOM - V_TOL); plan[1] = H_NOM - H_TOL; plan[2] = H_NOM + H_TOL; drive_frame(-1);
    plan_frame(V_NOM + V_TOL); drive_frame(-1);
    plan_frame(V_NOM - V_TOL - 1); drive_frame(-1);
    plan_frame(V_NOM); plan[3] = H_NOM - H_TOL - 1; drive_frame(-1);
    plan_frame(V_NOM); plan[5] = H_NOM + H_TOL + 1; drive_frame(-1);
    plan_frame(V_NOM + V_TOL + 1); drive_frame(-1);
    plan_frame(V_NOM); plan[V_NOM-1] = H_NOM + H_TOL + 1; drive_frame(-1);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      int n;
      n = V_NOM;
      if ($urandom_range(0, 3) == 0) n = V_NOM - 2 + int'($urandom_range(0, 4));
      plan_frame(n);
      for (int i = 0; i < n; i++)
        if ($urandom_range(0, 19) == 0) plan[i] = H_NOM - (H_TOL + 1) + int'($urandom_range(0, 2 * H_TOL + 2));
      drive_frame(-1);
    end

    // lock, then starve the watchdog
    run_nominal(6);
    wdog_test();
    run_nominal(7);

    // asynchronous reset mid-frame while locked
    plan_frame(V_NOM); drive_frame(3);
    run_nominal(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cps1_sync_lock_ctrl.md
# cps1_sync_lock_ctrl

Lock and output-gating controller for the CPS1 capture path. It sits directly after the sync-separating frontend and consumes its regenerated HSYNC/VSYNC/DE and frame-start strobe. It measures line length and lines per frame, and qualifies the timing against nominal CPS1 values. It opens the DE gate toward the scaler/output stage only after the timing has been stable for a programmable number of frames.

## Interface
Parameters:
- H_NOM, 1024: nominal PCLK2x cycles per line (512 px × 2)
- H_TOL, 4: allowed ± deviation of any line length, in cycles
- V_NOM, 262: nominal lines per frame
- V_TOL, 2: allowed ± deviation of lines per frame
- LOCK_FRAMES, 4: consecutive good frames needed to lock (1–15)
- UNLOCK_FRAMES, 2: consecutive bad frames needed to drop lock (1–15)
- WDOG_BITS, 20: width of the frame watchdog counter

Ports:
- PCLK2x_i  in  1  capture clock, 2× pixel rate
- reset_n  in  1  asynchronous, active-low reset
- HSYNC_i  in  1  frontend HSYNC, active low; falling edge = line start
- DE_i  in  1  frontend data enable
- frame_change_i  in  1  frontend frame strobe; rising edge = frame start, coincident with a line start
- DE_o  out  1  DE_i gated by out_en, registered
- locked_o  out  1  high in LOCKED or HOLD
- h_meas_o  out  11  last measured line length in cycles, saturating at 2047
- v_meas_o  out  10  last measured lines per frame, saturating at 1023
- frame_ok_o  out  1  one-cycle pulse: the frame just closed was valid
- wdog_timeout_o  out  1  one-cycle pulse: watchdog expired

## Operation
- Edge detection: registered copies of HSYNC_i and frame_change_i are kept. A line start (LS) is a 1→0 transition of HSYNC. A frame start (FS) is a 0→1 transition of frame_change. Every FS is also an LS.
- Line measurement: h_cnt increments every cycle and saturates at 2047. On LS, h_meas_o <= h_cnt+1 (saturating) and h_cnt <= 0. If |h_cnt+1 − H_NOM| > H_TOL, the sticky flag bad_line is set.
- Frame measurement: on a non-FS LS, line_cnt increments (saturating at 1023). On FS, v_meas_o <= line_cnt, line_cnt <= 1, and bad_line is cleared. The check of the closing line is included in this FS evaluation.
- Frame validity at FS: valid = seen_fs & ~bad_line_incl_current & |line_cnt − V_NOM| ≤ V_TOL. seen_fs is cleared by reset and by watchdog expiry, and set at the first FS, so the first partial frame is always discarded (neither good nor bad).
- State machine, transitions on FS only, except for the watchdog:
  - SEARCH: cnt=0. A valid frame → ACQUIRE with cnt=1, or directly LOCKED if LOCK_FRAMES=1.
  - ACQUIRE: a valid frame increments cnt; when cnt reaches LOCK_FRAMES → LOCKED with cnt=0. An invalid frame → SEARCH.
  - LOCKED: a valid frame stays in LOCKED. An invalid frame → HOLD with cnt=1, or SEARCH if UNLOCK_FRAMES=1.
  - HOLD: a valid frame → LOCKED with cnt=0. An invalid frame increments cnt; when cnt reaches UNLOCK_FRAMES → SEARCH.
- out_en = (state==LOCKED | state==HOLD). It therefore changes only at frame boundaries or on watchdog expiry.
- Watchdog: wd_cnt clears on FS and otherwise increments, saturating at all-ones. On reaching all-ones it pulses wdog_timeout_o once, forces SEARCH, and clears cnt and seen_fs. It does not pulse again until an FS occurs.
- frame_ok_o pulses for each valid FS regardless of state.

## Timing
- Reset values: DE_o=0, locked_o=0, h_meas_o=0, v_meas_o=0, frame_ok_o=0, wdog_timeout_o=0. State is SEARCH, all counters are 0, seen_fs=0.
- Edge detection adds 1 cycle. The LS/FS event is acted on in the cycle after the input edge is sampled.
- h_meas_o, v_meas_o, frame_ok_o, the state, and locked_o all update on the same clock edge, 2 cycles after the input edge.
- DE_o <= DE_i & out_en, giving 1 cycle latency relative to DE_i. In a frame where lock is gained, DE_o is first high on the first active line after that FS.
- If a watchdog expiry and an FS occur in the same cycle, the FS wins: wd_cnt clears and no timeout pulse is issued.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous reset). After release, one partial frame is discarded as for the first frame after power-up.

## Test plan
- Nominal stream of 262 lines × 1024 cycles from reset: frame_ok_o pulses at FS #2 through #5, locked_o rises at FS #5, v_meas_o=262, h_meas_o=1024, DE_o follows DE_i from that frame on.
- While locked, one frame of 265 lines followed by nominal frames: the state enters HOLD at that FS with locked_o still 1, and returns to LOCKED at the next FS. Two consecutive 265-line frames: locked_o drops to 0 at the second bad FS.
- While acquiring, one line of 1029 cycles (out of tolerance) inside frame 3: that FS is invalid, the state returns to SEARCH, and lock is reached 4 valid frames later.
- Boundary tolerance: 260-line frames and 1020/1028-cycle lines are all valid. 259-line frames and 1019-cycle lines are invalid.
- Inputs held static after lock: wdog_timeout_o pulses once 2^20−1 cycles after the last FS, locked_o=0 and DE_o=0 from then on, and there is no second pulse.
- reset_n pulsed low mid-frame while locked: all outputs read 0 during reset, and lock is regained at the 5th FS after release.
